// File: rtl/fp_div.sv
// rtl/fp_div.sv - iterative IEEE-754 single-precision divider, z = a / b
//
// Radix-2 restoring divider with a start/done handshake. Operands are captured
// when start is accepted in IDLE; z and status update on entry to DONE and hold
// until the next completion or reset.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   begin an operation (sampled only in IDLE)
//   a, b    dividend and divisor, IEEE single
//   rnd     rounding mode: 000 RNE, 001 RTZ, 010 +inf, 011 -inf, 100 away (101-111 -> 000)
//   busy    high from the cycle after start is accepted through the done cycle
//   done    one-cycle completion pulse
//   z       quotient
//   status  [0] zero [1] inf [2] nan [3] tiny [4] huge [5] inexact [6] div_by_zero [7] 0
//
// Optional feature macro: FP_DIV_EARLY_OUT_EN
//   When defined, special operands (zero, inf, NaN, denormal) skip DIVIDE.

module fp_div #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic        busy,
    output logic        done,
    output logic [31:0] z,
    output logic [7:0]  status
);

    localparam int         DIV_CYCLES = 26 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_CNT   = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  rnd_q;
    logic [24:0] rem;
    logic [25:0] q;
    logic [4:0]  cnt;

    // Any operand with exponent 0 (zero/denormal) or 255 (inf/NaN) bypasses the datapath.
    function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'd0) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'd0) || (y[30:23] == 8'hFF);
    endfunction

    // Divide step(s). The partial remainder always stays below the divisor
    // (< 2^24) after a step, so shifting it left fits in 25 bits.
    logic [24:0] dvs;
    logic [24:0] rem_nx;
    logic [25:0] q_nx;

    assign dvs = {2'b01, b_q[22:0]};

    always_comb begin
        rem_nx = rem;
        q_nx   = q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_nx >= dvs) begin
                rem_nx = rem_nx - dvs;
                q_nx   = {q_nx[24:0], 1'b1};
            end else begin
                q_nx   = {q_nx[24:0], 1'b0};
            end
            rem_nx = {rem_nx[23:0], 1'b0};
        end
    end

    // Normalise, round and classify the result.
    logic        sign;
    logic [9:0]  exp_raw;
    logic [9:0]  exp_adj;
    logic [9:0]  exp_fin;
    logic [23:0] mant;
    logic [23:0] mant_fin;
    logic [24:0] sum;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic        to_inf;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [31:0] res_z;
    logic [7:0]  res_st;

    always_comb begin
        sign    = a_q[31] ^ b_q[31];
        exp_raw = {2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'd127;
        if (q[25]) begin
            mant    = q[25:2];
            guard   = q[1];
            sticky  = q[0] | (rem != 25'd0);
            exp_adj = exp_raw;
        end else begin
            mant    = q[24:1];
            guard   = q[0];
            sticky  = (rem != 25'd0);
            exp_adj = exp_raw - 10'd1;
        end

        case (rnd_q)
            3'b000:  inc = guard & (sticky | mant[0]);
            3'b001:  inc = 1'b0;
            3'b010:  inc = ~sign & (guard | sticky);
            3'b011:  inc = sign & (guard | sticky);
            default: inc = guard | sticky;
        endcase

        sum = {1'b0, mant} + {24'd0, inc};
        if (sum[24]) begin
            mant_fin = sum[24:1];
            exp_fin  = exp_adj + 10'd1;
        end else begin
            mant_fin = sum[23:0];
            exp_fin  = exp_adj;
        end

        to_inf = (rnd_q == 3'b000) || (rnd_q == 3'b100) ||
                 ((rnd_q == 3'b010) && !sign) || ((rnd_q == 3'b011) && sign);

        res_z  = {sign, exp_fin[7:0], mant_fin[22:0]};
        res_st = {2'b00, guard | sticky, 5'b00000};
        if ($signed(exp_fin) >= 10'sd255) begin
            res_z  = to_inf ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7FFFFF};
            res_st = to_inf ? 8'h32 : 8'h30;
        end else if ($signed(exp_fin) <= 10'sd0) begin
            res_z  = {sign, 31'd0};
            res_st = 8'h29;
        end

        a_zero = (a_q[30:23] == 8'd0);
        b_zero = (b_q[30:23] == 8'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res_z  = 32'h7FC00000;
            res_st = 8'h04;
        end else if (a_inf) begin
            res_z  = {sign, 8'hFF, 23'd0};
            res_st = 8'h02;
        end else if (b_zero) begin
            res_z  = {sign, 8'hFF, 23'd0};
            res_st = 8'h42;
        end else if (a_zero || b_inf) begin
            res_z  = {sign, 31'd0};
            res_st = 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            z      <= 32'd0;
            status <= 8'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            rnd_q  <= 3'd0;
            rem    <= 25'd0;
            q      <= 26'd0;
            cnt    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        rnd_q <= (rnd > 3'd4) ? 3'd0 : rnd;
                        rem   <= {2'b01, a[22:0]};
                        q     <= 26'd0;
                        cnt   <= 5'd0;
                        busy  <= 1'b1;
`ifdef FP_DIV_EARLY_OUT_EN
                        state <= is_special(a, b) ? ROUND : DIVIDE;
`else
                        state <= DIVIDE;
`endif
                    end
                end
                DIVIDE: begin
                    rem <= rem_nx;
                    q   <= q_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST_CNT) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    z      <= res_z;
                    status <= res_st;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - scoreboard testbench for fp_div

module tb_fp_div;

    localparam int BPC   = 1;
    localparam int LAT_N = 26 / BPC + 2;
`ifdef FP_DIV_EARLY_OUT_EN
    localparam int LAT_S = 2;
`else
    localparam int LAT_S = LAT_N;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic        busy;
    logic        done;
    logic [31:0] z;
    logic [7:0]  status;

    fp_div #(.BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rnd(rnd),
        .busy(busy), .done(done), .z(z), .status(status)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] z;
        logic [7:0]  st;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got z=%h status=%h expected no completion", z, status);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_z"}, z, e.z);
                chk({e.name, "_status"}, {24'd0, status}, {24'd0, e.st});
                chk({e.name, "_latency"}, cyc - e.t0, e.lat);
            end
        end
    end

    task automatic launch(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [2:0] tr, input logic [31:0] ez, input logic [7:0] es,
                          input int elat);
        exp_t e;
        @(negedge clk);
        a = ta; b = tb_; rnd = tr; start = 1'b1;
        e.name = name; e.z = ez; e.st = es; e.lat = elat; e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done with a cycle budget; busy must stay high while waiting.
    task automatic wait_done(input string name);
        int  n;
        logic busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        chk({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic do_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [2:0] tr, input logic [31:0] ez, input logic [7:0] es,
                         input int elat);
        launch(name, ta, tb_, tr, ez, es, elat);
        wait_done(name);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; rnd = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_z",      z, 32'd0);
        chk("reset_status", {24'd0, status}, 32'd0);
        rst = 1'b0;

        do_op("six_div_two",   32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 8'h00, LAT_N);
        do_op("third_rne",     32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 8'h20, LAT_N);
        do_op("third_rtz",     32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 8'h20, LAT_N);
        do_op("third_rnd5",    32'h3F800000, 32'h40400000, 3'b101, 32'h3EAAAAAB, 8'h20, LAT_N);
        do_op("neg_third_up",  32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAA, 8'h20, LAT_N);
        do_op("neg_third_dn",  32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAB, 8'h20, LAT_N);
        do_op("sticky_rne",    32'h3F800000, 32'h3F800001, 3'b000, 32'h3F7FFFFE, 8'h20, LAT_N);
        do_op("sticky_away",   32'h3F800000, 32'h3F800001, 3'b100, 32'h3F7FFFFF, 8'h20, LAT_N);
        do_op("div_by_zero",   32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 8'h42, LAT_S);
        do_op("zero_by_zero",  32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 8'h04, LAT_S);
        do_op("nan_operand",   32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 8'h04, LAT_S);
        do_op("inf_by_two",    32'h7F800000, 32'h40000000, 3'b000, 32'h7F800000, 8'h02, LAT_S);
        do_op("two_by_inf",    32'h40000000, 32'h7F800000, 3'b000, 32'h00000000, 8'h01, LAT_S);
        do_op("ovf_rne",       32'h7F000000, 32'h3E800000, 3'b000, 32'h7F800000, 8'h32, LAT_N);
        do_op("ovf_rtz",       32'h7F000000, 32'h3E800000, 3'b001, 32'h7F7FFFFF, 8'h30, LAT_N);
        do_op("ovf_up",        32'h7F000000, 32'h3E800000, 3'b010, 32'h7F800000, 8'h32, LAT_N);
        do_op("ovf_down",      32'h7F000000, 32'h3E800000, 3'b011, 32'h7F7FFFFF, 8'h30, LAT_N);
        do_op("underflow",     32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 8'h29, LAT_N);

        // A start while busy and a start during DONE must both be ignored.
        launch("busy_start", 32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 8'h20, LAT_N);
        repeat (3) @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; rnd = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy",   {31'd0, busy}, 32'd0);
        chk("midrst_done",   {31'd0, done}, 32'd0);
        chk("midrst_z",      z, 32'd0);
        chk("midrst_status", {24'd0, status}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        do_op("after_reset", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 8'h00, LAT_N);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
